pg_nbit_seq: RTL
================

Name: pg_nbit_seq

Overview:
- Parametrised N-bit pattern generator; successor to the fixed 4-bit pattern generator.
- Plays a programmable table of WIDTH-bit words, a binary count, or a PRBS sequence, with a programmable step divider.
- Sits behind the tile I/O wrapper: the config port is driven from ui_in/uio_in, and pat_out drives uo_out.

Parameters:
- WIDTH, 8, output pattern width in bits (2..16).
- ADDR_W, 4, table address width; DEPTH = 2**ADDR_W entries.
- DIV_W, 8, width of the step divider.
- LFSR_POLY, 8'hB8, Galois feedback mask for PRBS mode; WIDTH bits wide.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  ADDR_W  table write address.
- cfg_data  in  WIDTH  table write data.
- mode  in  2  0=ONESHOT, 1=LOOP, 2=COUNT, 3=PRBS; sampled on start.
- len  in  ADDR_W  last table index (ONESHOT/LOOP) or count limit (COUNT); sampled on start.
- div  in  DIV_W  step held for div+1 clocks; sampled on start.
- start  in  1  begin playback (level, sampled each clock).
- stop  in  1  abort playback.
- pat_out  out  WIDTH  current pattern word.
- pat_valid  out  1  high while pat_out carries a played word.
- busy  out  1  high in RUN.
- done  out  1  one-clock pulse at ONESHOT completion.
- idx  out  ADDR_W  current table index; 0 in COUNT/PRBS.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pat_out=0, pat_valid=0, busy=0, done=0, idx=0, divider=0, LFSR=0.
  - Table contents are not reset.
- Table writes: on a clock edge with cfg_we=1 and state=IDLE, mem[cfg_addr]<=cfg_data. Writes while busy are dropped.
- FSM states: IDLE, RUN.
- IDLE->RUN: start=1 and stop=0 at edge k. Latch mode, div, and len. At edge k, drive:
  - busy=1, pat_valid=1, idx=0, divider=0.
  - pat_out depends on mode: mem[0] (ONESHOT/LOOP), 0 (COUNT), seed (PRBS).
  - Outputs are visible after edge k, i.e. one-clock latency from start.
- PRBS seed is mem[0]; if mem[0]==0 the seed is 1.
- Step rule:
  - The divider counts 0..div_latched.
  - When it equals div_latched, it returns to 0 and the pattern advances on the same edge.
  - Each word is therefore held exactly div+1 clocks; div=0 advances every clock.
- Advance by mode:
  - ONESHOT: idx<len -> idx+1, pat_out=mem[idx+1]. idx==len -> go to IDLE: done=1 for one clock, busy=0, pat_valid=0, pat_out=0.
  - LOOP: idx==len wraps to 0 (pat_out=mem[0]); otherwise idx+1. Runs until stop.
  - COUNT: pat_out+1, wrapping to 0 after zero-extended len. The limit len is compared against WIDTH bits. Runs until stop.
  - PRBS: Galois LFSR. If lsb=1: next=(cur>>1)^LFSR_POLY; else next=cur>>1. Runs until stop.
- stop=1 in RUN: next edge returns to IDLE with busy=0, pat_valid=0, pat_out=0. No done pulse.
- Simultaneous events:
  - start and stop in IDLE on the same edge: stop wins, state stays IDLE.
  - start in RUN is ignored; the latched mode/len/div are unaffected.
  - ONESHOT final step and stop on the same edge: stop wins, no done.
- len=0: ONESHOT plays mem[0] for div+1 clocks, then done. LOOP holds mem[0] indefinitely.
- Reset asserted mid-run: all outputs go to their reset values immediately (async). No done pulse.
- done and busy are never high together on the same clock.

Test Plan:
1. Reset mid-run: in LOOP, assert rst_n=0 -> pat_out=0, busy=0, pat_valid=0 immediately; restart after release works.
2. ONESHOT basic: write mem[0..3]=8'h11,22,33,44; mode=0, len=3, div=0; pulse start -> pat_out 11,22,33,44 on 4 consecutive clocks; then done=1 for 1 clock with pat_out=0, busy=0.
3. LOOP with divider: same table, mode=1, len=2, div=2 -> each of 11,22,33 held 3 clocks, sequence repeats; stop -> pat_out=0 next clock, done stays 0.
4. COUNT: mode=2, len=5, div=0 -> 0,1,2,3,4,5,0,1...; a cfg_we to mem[0] while busy leaves mem[0] unchanged (check later ONESHOT).
5. PRBS: mem[0]=0, mode=3 -> first word 8'h01, next 8'hB8, then 8'h5C; run 255 steps -> returns to 8'h01 (maximal length), never 0.
6. Collisions: start+stop in IDLE -> stays idle. Start during RUN -> no restart. ONESHOT len=0, div=1 -> mem[0] held 2 clocks, then done.

Source files
------------

// File: rtl/pg_nbit_seq.sv
// Parametrised pattern generator: plays a WIDTH-bit word table (one-shot or
// looped), a binary count, or a Galois PRBS, each word held div+1 clocks.
module pg_nbit_seq #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int DIV_W  = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY = 'hB8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] len,
  input  logic [DIV_W-1:0]  div,
  input  logic              start,
  input  logic              stop,
  output logic [WIDTH-1:0]  pat_out,
  output logic              pat_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] idx
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] M_ONESHOT = 2'd0;
  localparam logic [1:0] M_LOOP    = 2'd1;
  localparam logic [1:0] M_COUNT   = 2'd2;
  localparam logic [1:0] M_PRBS    = 2'd3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [1:0]         mode_q;
  logic [ADDR_W-1:0]  len_q;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   div_cnt;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]  idx_inc;
  logic [WIDTH-1:0]   count_lim;
  logic [WIDTH-1:0]   lfsr_nxt;
  logic [WIDTH-1:0]   prbs_seed;

  assign idx_inc   = idx + ADDR_W'(1);
  assign count_lim = WIDTH'(len_q);
  assign lfsr_nxt  = pat_out[0] ? ((pat_out >> 1) ^ LFSR_POLY) : (pat_out >> 1);
  // An all-zero seed would lock the LFSR, so it is forced to 1.
  assign prbs_seed = (mem[0] == '0) ? WIDTH'(1) : mem[0];

  // Table is only writable while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= M_ONESHOT;
      len_q     <= '0;
      div_q     <= '0;
      div_cnt   <= '0;
      pat_out   <= '0;
      pat_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            mode_q    <= mode;
            len_q     <= len;
            div_q     <= div;
            div_cnt   <= '0;
            idx       <= '0;
            busy      <= 1'b1;
            pat_valid <= 1'b1;
            case (mode)
              M_ONESHOT, M_LOOP: pat_out <= mem[0];
              M_COUNT:           pat_out <= '0;
              default:           pat_out <= prbs_seed;
            endcase
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            busy      <= 1'b0;
            pat_valid <= 1'b0;
            pat_out   <= '0;
            idx       <= '0;
            div_cnt   <= '0;
          end else if (div_cnt != div_q) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            case (mode_q)
              M_ONESHOT: begin
                if (idx != len_q) begin
                  idx     <= idx_inc;
                  pat_out <= mem[idx_inc];
                end else begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  pat_valid <= 1'b0;
                  pat_out   <= '0;
                  idx       <= '0;
                end
              end
              M_LOOP: begin
                if (idx == len_q) begin
                  idx     <= '0;
                  pat_out <= mem[0];
                end else begin
                  idx     <= idx_inc;
                  pat_out <= mem[idx_inc];
                end
              end
              M_COUNT: pat_out <= (pat_out == count_lim) ? '0 : pat_out + WIDTH'(1);
              default: pat_out <= lfsr_nxt;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
